// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache.
// Latency: none (wires only).
// Backpressure: none here; the cache stalls the PC via hit and memory paces refill via memValid.
interface inst_cache_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] instAddr;
   logic              flush;
   logic              hit;
   logic [DATA_W-1:0] inst;
   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memRdata;
   logic              memValid;

   // PC/memory environment drives lookups and refill beats
   modport master (
      output instAddr, flush, memRdata, memValid,
      input  hit, inst, memReq, memAddr
   );

   // cache answers lookups and requests refills
   modport slave (
      input  instAddr, flush, memRdata, memValid,
      output hit, inst, memReq, memAddr
   );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between the PC and instruction memory.
// Latency: hit is combinational from instAddr; a miss hits again 2**OFFSET_W beats + 2 cycles later.
// Backpressure: hit=0 stalls the PC; memValid=0 stretches a refill indefinitely; flush aborts it.
module inst_cache #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int INDEX_W  = 4,
   parameter int OFFSET_W = 2
) (
   input  logic          clk,
   input  logic          rst,
   inst_cache_if.slave   bus
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 2**INDEX_W;
   localparam int WORDS = 2**OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, REFILL, FILLDONE} state_t;

   state_t state, next_state;

   // address split of the current fetch: {tag, index, offset}
   logic [TAG_W-1:0]    addr_tag;
   logic [INDEX_W-1:0]  addr_idx;
   logic [OFFSET_W-1:0] addr_off;

   // line state; tag and data arrays carry no reset, valid bits guard them
   logic [LINES-1:0]    valid;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [LINES*WORDS];

   // refill context captured on the miss edge
   logic [TAG_W-1:0]    lat_tag;
   logic [INDEX_W-1:0]  lat_idx;
   logic [OFFSET_W-1:0] beat;
   logic [ADDR_W-1:0]   mem_addr;

   logic lookup_hit;
   logic miss_start;
   logic beat_wr;
   logic commit;

   assign addr_off = bus.instAddr[OFFSET_W-1:0];
   assign addr_idx = bus.instAddr[OFFSET_W +: INDEX_W];
   assign addr_tag = bus.instAddr[ADDR_W-1 -: TAG_W];

   assign lookup_hit = (state == IDLE) && valid[addr_idx] &&
                       (tag_mem[addr_idx] == addr_tag) && !bus.flush;

   assign bus.hit     = lookup_hit;
   assign bus.inst    = data_mem[{addr_idx, addr_off}];
   assign bus.memReq  = (state == REFILL);
   assign bus.memAddr = mem_addr;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // next-state and per-cycle control strobes; flush overrides everything
   always_comb begin
      next_state = state;
      miss_start = 1'b0;
      beat_wr    = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.flush && !lookup_hit) begin
               next_state = REFILL;
               miss_start = 1'b1;
            end
         end
         REFILL: begin
            if (bus.memValid) begin
               beat_wr = 1'b1;
               if (beat == LAST_BEAT) next_state = FILLDONE;
            end
         end
         FILLDONE: begin
            commit     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (bus.flush) begin
         next_state = IDLE;
         miss_start = 1'b0;
         beat_wr    = 1'b0;
         commit     = 1'b0;
      end
   end

   // valid bits, refill context, beat counter and refill base address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= '0;
         lat_tag  <= '0;
         lat_idx  <= '0;
         beat     <= '0;
         mem_addr <= '0;
      end else begin
         if (bus.flush) begin
            valid <= '0;
         end else begin
            // the victim line stays invalid for the whole refill
            if (miss_start) valid[addr_idx] <= 1'b0;
            if (commit)     valid[lat_idx]  <= 1'b1;
         end
         if (miss_start) begin
            lat_tag  <= addr_tag;
            lat_idx  <= addr_idx;
            beat     <= '0;
            mem_addr <= {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
         end else if (beat_wr) begin
            beat <= beat + 1'b1;
         end
      end
   end

   // data beats and tag commit into the unreset arrays
   always_ff @(posedge clk) begin
      if (beat_wr) data_mem[{lat_idx, beat}] <= bus.memRdata;
      if (commit)  tag_mem[lat_idx]          <= lat_tag;
   end
endmodule
